// File: rtl/mux_stim_sequencer.sv
// mux_stim_sequencer: exhaustive stimulus sweep for a 2:1 multiplexer.
// The eight {s,in0,in1} vectors are walked in order. Each vector is held for
// DWELL cycles. The returned mux_out may be compared against the ideal mux
// function at dwell offset SETTLE.
// Optional feature macro: MUX_SEQ_CHECK_EN. It enables the sample/compare path
// and the err_cnt accumulator. Without it, mux_out is ignored and err_cnt reads 0.

// Property checker for the sequencer outputs. It is kept apart from the logic
// so that the datapath stays free of verification constructs.
module mux_stim_sequencer_chk #(
  parameter int DWELL  = 10,
  parameter int SETTLE = 5
) (
  input logic       clk,
  input logic       rst_n,
  input logic       busy,
  input logic       done,
  input logic       s,
  input logic       in0,
  input logic       in1,
  input logic [2:0] vec_idx
);

  // Sampling point must fall inside the dwell window of a legal length
  a_param_range: assert property (@(posedge clk) disable iff (!rst_n)
    (DWELL >= 2) && (DWELL <= 255) && (SETTLE >= 1) && (SETTLE < DWELL));

  // RUN and DONE are distinct states, so busy and done never overlap
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

  // done lasts exactly one cycle
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  // A sweep can only finish on the last vector
  a_done_last: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> (vec_idx == 3'd7));

  // Stimulus pins are a direct decode of the vector index
  a_stim_map: assert property (@(posedge clk) disable iff (!rst_n)
    ({s, in0, in1} == vec_idx));

endmodule

module mux_stim_sequencer #(
  parameter int DWELL  = 10,
  parameter int SETTLE = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       loop,
  input  logic       mux_out,
  output logic       in0,
  output logic       in1,
  output logic       s,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [2:0] VEC_LAST   = 3'd7;
  localparam logic [3:0] ERR_MAX    = 4'd15;

  state_t     state_r;
  state_t     state_nx_s;
  logic [2:0] vec_r;
  logic [2:0] vec_nx_s;
  logic [7:0] dwell_r;
  logic [7:0] dwell_nx_s;
  logic [3:0] err_r;
  logic [3:0] err_nx_s;
  logic       armed_r;
  logic       busy_r;
  logic       done_r;
  logic       accept_s;
  logic       dwell_end_s;

  // Ideal 2:1 mux response for a vector encoded as {s,in0,in1}
  function automatic logic mux_expect(input logic [2:0] vec);
    return vec[2] ? vec[0] : vec[1];
  endfunction

  // armed_r is low during the first edge after reset. A start that
  // coincides with reset release is therefore never accepted.
  assign accept_s    = (state_r == ST_IDLE) && start && armed_r;
  assign dwell_end_s = (dwell_r == DWELL_LAST);

  // Next-state and vector/dwell sequencing
  always_comb begin
    state_nx_s = state_r;
    vec_nx_s   = vec_r;
    dwell_nx_s = dwell_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_RUN;
          vec_nx_s   = 3'd0;
          dwell_nx_s = 8'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (dwell_end_s) begin
          dwell_nx_s = 8'd0;
          if (vec_r != VEC_LAST) begin
            vec_nx_s = vec_r + 3'd1;
          end else if (loop) begin
            vec_nx_s = 3'd0;
          end else begin
            // Vector 7 stays on the pins through DONE and IDLE
            state_nx_s = ST_DONE;
          end
        end else begin
          dwell_nx_s = dwell_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
        vec_nx_s   = 3'd0;
        dwell_nx_s = 8'd0;
      end
    endcase
  end

`ifdef MUX_SEQ_CHECK_EN
  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  logic sample_s;
  logic mismatch_s;

  assign sample_s   = (state_r == ST_RUN) && (dwell_r == SETTLE_CNT);
  assign mismatch_s = sample_s && (mux_out != mux_expect(vec_r));

  // Mismatch accumulator: cleared on accepted start, saturating at 15
  always_comb begin
    err_nx_s = err_r;
    if (accept_s) begin
      err_nx_s = 4'd0;
    end else if (mismatch_s && (err_r != ERR_MAX)) begin
      err_nx_s = err_r + 4'd1;
    end else begin
      err_nx_s = err_r;
    end
  end
`else
  logic unused_mux_out_s;

  assign unused_mux_out_s = mux_out ^ mux_expect(vec_r);

  // Checking disabled: the error count is held at zero
  always_comb begin
    err_nx_s = 4'd0;
  end
`endif

  // FSM state, vector, dwell, error and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      vec_r   <= 3'd0;
      dwell_r <= 8'd0;
      err_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      vec_r   <= vec_nx_s;
      dwell_r <= dwell_nx_s;
      err_r   <= err_nx_s;
      busy_r  <= (state_nx_s == ST_RUN);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  // Start-acceptance guard, set by the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= 1'b1;
    end
  end

  assign vec_idx = vec_r;
  assign s       = vec_r[2];
  assign in0     = vec_r[1];
  assign in1     = vec_r[0];
  assign busy    = busy_r;
  assign done    = done_r;
  assign err_cnt = err_r;

  mux_stim_sequencer_chk #(
    .DWELL  (DWELL),
    .SETTLE (SETTLE)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy_r),
    .done    (done_r),
    .s       (vec_r[2]),
    .in0     (vec_r[1]),
    .in1     (vec_r[0]),
    .vec_idx (vec_r)
  );

endmodule

// File: doc/mux_stim_sequencer.md
MUX_STIM_SEQUENCER -- requirements
Module: mux_stim_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 10: clock cycles each input vector is held; legal range 2..255.
REQ-002 SHALL have parameter SETTLE, default 5: cycle offset within the dwell at which mux_out is sampled; legal range 1..DWELL-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: a one-cycle request to begin a sweep.
REQ-006 SHALL have port loop, input, 1: when high at the end of vector 7, the sweep wraps to vector 0 instead of finishing.
REQ-007 SHALL have port mux_out, input, 1: the output returned from the 2-1 multiplexer under test.
REQ-008 SHALL have ports in0, in1 and s, each output, 1: the data and select stimulus driven to the multiplexer.
REQ-009 SHALL have port vec_idx, output, 3: the index of the current vector, encoded as {s,in0,in1}.
REQ-010 SHALL have port busy, output, 1: high while in RUN.
REQ-011 SHALL have port done, output, 1: a one-cycle pulse when a sweep finishes.
REQ-012 SHALL have port err_cnt, output, 4: the number of mismatches since the last accepted start.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL move from IDLE to RUN when start=1: vec_idx<=0, dwell counter<=0, err_cnt<=0.
REQ-015 SHALL ignore start while in RUN or DONE; no restart and no clear occurs.
REQ-016 SHALL drive s=vec_idx[2], in0=vec_idx[1] and in1=vec_idx[0] from registers, so outputs change in the same cycle vec_idx changes.
REQ-017 SHALL count the dwell counter 0..DWELL-1 in RUN; each vector is therefore held exactly DWELL cycles.
REQ-018 SHALL sample mux_out when the dwell counter equals SETTLE and compare it against expected = s ? in1 : in0.
REQ-019 SHALL increment err_cnt by one on a mismatch and saturate it at 15; err_cnt is updated in the cycle after the sample edge.
REQ-020 SHALL, when the dwell counter equals DWELL-1 and vec_idx<7, increment vec_idx and clear the dwell counter.
REQ-021 SHALL, when the dwell counter equals DWELL-1 and vec_idx=7 and loop=1, wrap vec_idx to 0, keep err_cnt, stay in RUN and not assert done.
REQ-022 SHALL, when the dwell counter equals DWELL-1 and vec_idx=7 and loop=0, go to DONE.
REQ-023 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-024 SHALL hold vec_idx, in0, in1, s and err_cnt at their last values in IDLE.
REQ-025 SHALL, if loop drops mid-sweep, finish at the next vector-7 end; loop is sampled only at that point.
REQ-026 SHALL take 8*DWELL cycles plus 1 DONE cycle from the start acceptance to done.

Reset
REQ-027 SHALL, on rst_n low, immediately set state=IDLE, vec_idx=0, the dwell counter=0, in0=in1=s=0, busy=0, done=0 and err_cnt=0, regardless of the clock.
REQ-028 SHALL abort a sweep in progress when reset is asserted; no done pulse is produced.
REQ-029 SHALL not treat a start coinciding with the reset release edge as accepted.

Configuration
REQ-030 SHALL, with MUX_SEQ_CHECK_EN defined, include the sampling and compare logic of REQ-018/019.
REQ-031 SHALL, without MUX_SEQ_CHECK_EN, ignore mux_out, tie err_cnt to 0 and leave all other behaviour unchanged.

Verification
REQ-032 SHALL cover: DWELL=10, SETTLE=5, ideal mux model, start pulse -> vec_idx steps 0..7 every 10 cycles, done at cycle 81, err_cnt=0.
REQ-033 SHALL cover: mux model stuck at 0 -> err_cnt=4 at done (vectors 2, 3, 5, 7 expect 1).
REQ-034 SHALL cover: a mux model with a 7-cycle delay, SETTLE=5 -> mismatches counted; rerun with SETTLE=8 -> err_cnt=0.
REQ-035 SHALL cover: loop=1 with stuck-at-0 for 5 sweeps -> no done, err_cnt saturates at 15; loop->0 -> done after the current sweep.
REQ-036 SHALL cover: rst_n low at cycle 37 -> all outputs 0 asynchronously, busy=0, no done; start resumes from vector 0.
REQ-037 SHALL cover: start pulsed again during RUN -> no effect on vec_idx or err_cnt; build without MUX_SEQ_CHECK_EN -> err_cnt stays 0 with the stuck model.
